// File: rtl/bcd_alu_if.sv
// Operation request/result bundle for bcd_alu: request fields driven by the
// master, status and result fields driven by the ALU (slave).
interface bcd_alu_if #(parameter int DIGITS = 6);
    logic                  start;
    logic [1:0]            op;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  neg;
    logic                  ovf;
    logic                  err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, neg, ovf, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, neg, ovf, err
    );
endinterface

// File: rtl/bcd_alu.sv
// Packed-BCD ALU: single-cycle add/sub, digit-serial shift-and-add multiply.
// Optional macro BCD_ALU_SAT_EN saturates add/mul results to all 9s on overflow.
module bcd_alu #(
    parameter int DIGITS = 6
) (
    input  logic      CLOCK_50,
    input  logic      rst,
    bcd_alu_if.slave  bus
);

    localparam int W  = 4 * DIGITS;
    localparam int AW = 8 * DIGITS;
    localparam int DW = $clog2(DIGITS);
    localparam logic [DW-1:0] DIG_MAX = DW'(DIGITS - 1);
    localparam logic [W-1:0]  ALL9 = {DIGITS{4'h9}};
`ifdef BCD_ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MSHIFT, MADD, DONE} state_t;

    // One decimal digit add; bit 4 of the return value is the decimal carry.
    function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic cin);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'd0, cin};
        if (s > 5'd9) s = s + 5'd6;
        return s;
    endfunction

    function automatic logic [W:0] bcd_add_w(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic cin);
        logic       c;
        logic [4:0] s;
        logic [W:0] r;
        c = cin;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            s = digit_add(x[4*i +: 4], y[4*i +: 4], c);
            r[4*i +: 4] = s[3:0];
            c = s[4];
        end
        r[W] = c;
        return r;
    endfunction

    // The product never exceeds 2*DIGITS digits, so the final carry is dropped.
    function automatic logic [AW-1:0] bcd_add_acc(input logic [AW-1:0] x, input logic [AW-1:0] y);
        logic          c;
        logic [4:0]    s;
        logic [AW-1:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 2*DIGITS; i++) begin
            s = digit_add(x[4*i +: 4], y[4*i +: 4], c);
            r[4*i +: 4] = s[3:0];
            c = s[4];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] nines(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9 - x[4*i +: 4];
        return r;
    endfunction

    function automatic logic [W-1:0] tens_comp(input logic [W-1:0] x);
        logic         c;
        logic [4:0]   s;
        logic [W-1:0] r;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            s = digit_add(4'd9 - x[4*i +: 4], 4'd0, c);
            r[4*i +: 4] = s[3:0];
            c = s[4];
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] x);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) if (x[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [W-1:0] sat_fit(input logic [W-1:0] r, input logic o);
        return (SAT_EN && o) ? ALL9 : r;
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic [W-1:0]    result_q, result_d;
    logic            neg_q, neg_d, ovf_q, ovf_d, err_q, err_d;
    logic [W:0]      add_r;
    logic [3:0]      cur_dig;
    logic            mul_fin, mul_ovf;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dig_d    = dig_q;
        result_d = result_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        add_r    = '0;
        cur_dig  = b_q[4*dig_q +: 4];
        mul_fin  = 1'b0;
        mul_ovf  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    acc_d = '0;
                    cnt_d = '0;
                    dig_d = DIG_MAX;
                    if (has_bad(bus.a) || has_bad(bus.b) || bus.op == 2'b11) begin
                        result_d = '0;
                        neg_d    = 1'b0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else if (bus.op == 2'b00) begin
                        add_r    = bcd_add_w(bus.a, bus.b, 1'b0);
                        result_d = sat_fit(add_r[W-1:0], add_r[W]);
                        neg_d    = 1'b0;
                        ovf_d    = add_r[W];
                        err_d    = 1'b0;
                        state_d  = DONE;
                    end else if (bus.op == 2'b01) begin
                        // No carry out means a < b: the sum is the 10's complement of b-a.
                        add_r    = bcd_add_w(bus.a, nines(bus.b), 1'b1);
                        result_d = add_r[W] ? add_r[W-1:0] : tens_comp(add_r[W-1:0]);
                        neg_d    = ~add_r[W];
                        ovf_d    = 1'b0;
                        err_d    = 1'b0;
                        state_d  = DONE;
                    end else begin
                        state_d  = MSHIFT;
                    end
                end
            end
            MSHIFT: begin
                acc_d = {acc_q[AW-5:0], 4'd0};
                cnt_d = cur_dig;
                if (cur_dig != 4'd0)    state_d = MADD;
                else if (dig_q == '0)   mul_fin = 1'b1;
                else                    dig_d = dig_q - DW'(1);
            end
            MADD: begin
                acc_d = bcd_add_acc(acc_q, {{W{1'b0}}, a_q});
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (dig_q == '0) begin
                        mul_fin = 1'b1;
                    end else begin
                        dig_d   = dig_q - DW'(1);
                        state_d = MSHIFT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (mul_fin) begin
            mul_ovf  = |acc_d[AW-1:W];
            result_d = sat_fit(acc_d[W-1:0], mul_ovf);
            neg_d    = 1'b0;
            ovf_d    = mul_ovf;
            err_d    = 1'b0;
            state_d  = DONE;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dig_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = (state_q == MSHIFT) || (state_q == MADD);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.neg    = neg_q;
    assign bus.ovf    = ovf_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_alu.sv
// Testbench for bcd_alu (DIGITS=6): directed vector table, hand sequences for
// back-to-back, reset priority and abort, then random ops against a numeric model.
module tb_bcd_alu;

    localparam int D = 6;
    localparam int W = 4 * D;
`ifdef BCD_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    bcd_alu_if #(.DIGITS(D)) bus ();
    bcd_alu #(.DIGITS(D)) dut (.CLOCK_50(clk), .rst(rst), .bus(bus));

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         neg;
        logic         ovf;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] satv(input logic [W-1:0] trunc);
        return SAT ? {D{4'h9}} : trunc;
    endfunction

    function automatic longint bcd2int(input logic [W-1:0] x);
        longint v = 0;
        for (int i = D - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        longint t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit bad_digits(input logic [W-1:0] x);
        for (int i = 0; i < D; i++) if (x[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Reference behaviour from plain integer arithmetic.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic neg, output logic ovf,
                         output logic err, output int lat);
        longint m = 1;
        longint av, bv, r;
        int dsum = 0;
        for (int i = 0; i < D; i++) m = m * 10;
        res = '0; neg = 1'b0; ovf = 1'b0; err = 1'b0; lat = 1;
        if (op == 2'b11 || bad_digits(a) || bad_digits(b)) begin
            err = 1'b1;
            return;
        end
        av = bcd2int(a);
        bv = bcd2int(b);
        case (op)
            2'b00: begin r = av + bv; ovf = (r >= m); end
            2'b01: begin
                if (av >= bv) r = av - bv;
                else begin r = bv - av; neg = 1'b1; end
            end
            default: begin
                r = av * bv;
                ovf = (r >= m);
                for (int i = 0; i < D; i++) dsum += int'(b[4*i +: 4]);
                lat = D + dsum + 1;
            end
        endcase
        res = (ovf && SAT) ? {D{4'h9}} : int2bcd(r % m);
    endtask

    // Called at a point where the DUT is idle; returns one cycle after done.
    task automatic run_op(input string tag, input logic [1:0] op_i, input logic [W-1:0] a_i,
                          input logic [W-1:0] b_i, input logic [W-1:0] e_res, input logic e_neg,
                          input logic e_ovf, input logic e_err, input int e_lat);
        int got_lat = -1;
        int busy_bad = 0;
        bus.start = 1'b1;
        bus.op = op_i;
        bus.a = a_i;
        bus.b = b_i;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.op = 2'($urandom);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (bus.busy !== (e_lat > 1 && cyc < e_lat)) busy_bad++;
            if (bus.done === 1'b1) begin
                got_lat = cyc;
                break;
            end
        end
        check({tag, ".latency"}, got_lat, e_lat);
        check({tag, ".busy"}, busy_bad, 0);
        check({tag, ".result"}, bus.result, e_res);
        check({tag, ".neg"}, bus.neg, e_neg);
        check({tag, ".ovf"}, bus.ovf, e_ovf);
        check({tag, ".err"}, bus.err, e_err);
        @(negedge clk);
        check({tag, ".done_pulse"}, bus.done, 0);
        check({tag, ".hold"}, bus.result, e_res);
    endtask

    initial begin
        logic [W-1:0] ra, rb, er;
        logic [1:0]   rop;
        logic         en, eo, ee;
        int           el, no_done;

        vecs[0]  = '{2'b00, 24'h999999, 24'h000001, satv(24'h000000), 1'b0, 1'b1, 1'b0, 1};
        vecs[1]  = '{2'b01, 24'h000123, 24'h000456, 24'h000333, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{2'b01, 24'h000456, 24'h000123, 24'h000333, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{2'b10, 24'h000012, 24'h000034, 24'h000408, 1'b0, 1'b0, 1'b0, 14};
        vecs[4]  = '{2'b10, 24'h001000, 24'h001000, satv(24'h000000), 1'b0, 1'b1, 1'b0, 8};
        vecs[5]  = '{2'b00, 24'h00000A, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1, 1};
        vecs[6]  = '{2'b11, 24'h000123, 24'h000456, 24'h000000, 1'b0, 1'b0, 1'b1, 1};
        vecs[7]  = '{2'b01, 24'h000777, 24'h000777, 24'h000000, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{2'b00, 24'h123456, 24'h654321, 24'h777777, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{2'b10, 24'h999999, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 7};
        vecs[10] = '{2'b10, 24'h000000, 24'h000009, 24'h000000, 1'b0, 1'b0, 1'b0, 16};
        vecs[11] = '{2'b10, 24'h000001, 24'h0000F0, 24'h000000, 1'b0, 1'b0, 1'b1, 1};
        vecs[12] = '{2'b01, 24'h000000, 24'h999999, 24'h999999, 1'b1, 1'b0, 1'b0, 1};
        vecs[13] = '{2'b00, 24'h500000, 24'h500000, satv(24'h000000), 1'b0, 1'b1, 1'b0, 1};
        vecs[14] = '{2'b10, 24'h999999, 24'h999999, satv(24'h000001), 1'b0, 1'b1, 1'b0, 61};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.done, 0);
        check("reset.result", bus.result, 0);
        check("reset.neg", bus.neg, 0);
        check("reset.ovf", bus.ovf, 0);
        check("reset.err", bus.err, 0);

        for (int i = 0; i < 15; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].neg, vecs[i].ovf, vecs[i].err, vecs[i].lat);

        // start held high: the DONE cycle ignores it, the next cycle accepts it
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 24'h000001; bus.b = 24'h000002;
        @(posedge clk); #1;
        bus.a = 24'h000005; bus.b = 24'h000005;
        @(negedge clk);
        check("b2b.done1", bus.done, 1);
        check("b2b.res1", bus.result, 24'h000003);
        @(negedge clk);
        check("b2b.gap", bus.done, 0);
        check("b2b.hold", bus.result, 24'h000003);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("b2b.done2", bus.done, 1);
        check("b2b.res2", bus.result, 24'h000010);
        @(negedge clk);

        // reset wins over a simultaneous start
        rst = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.a = 24'h000001; bus.b = 24'h000001;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("rstpri.done", bus.done, 0);
        check("rstpri.result", bus.result, 0);
        @(negedge clk);
        check("rstpri.done_next", bus.done, 0);

        // abort a multiply: extra start at cycles 3..4, reset at cycle 5
        run_op("pre_abort", 2'b00, 24'h000001, 24'h000002, 24'h000003, 1'b0, 1'b0, 1'b0, 1);
        no_done = 0;
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 24'h000012; bus.b = 24'h000034;
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk); if (bus.done) no_done++;
        @(posedge clk); #1;
        @(negedge clk); if (bus.done) no_done++;
        @(posedge clk); #1 bus.start = 1'b1;
        @(negedge clk); if (bus.done) no_done++;
        check("abort.busy_c3", bus.busy, 1);
        @(posedge clk); #1;
        @(negedge clk); if (bus.done) no_done++;
        @(posedge clk); #1 begin bus.start = 1'b0; rst = 1'b1; end
        @(negedge clk); if (bus.done) no_done++;
        check("abort.busy_c5", bus.busy, 1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort.busy", bus.busy, 0);
        check("abort.done", bus.done, 0);
        check("abort.result", bus.result, 0);
        check("abort.neg", bus.neg, 0);
        check("abort.ovf", bus.ovf, 0);
        check("abort.err", bus.err, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) no_done++;
        end
        check("abort.no_done", no_done, 0);

        for (int n = 0; n < 40; n++) begin
            rop = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ra = '0;
            rb = '0;
            for (int i = 0; i < D; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if (rop == 2'b10 && $urandom_range(0, 1) == 1) ra = ra >> (4 * $urandom_range(1, D - 1));
            if ($urandom_range(0, 11) == 0) ra[4*$urandom_range(0, D - 1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 11) == 0) rb[4*$urandom_range(0, D - 1) +: 4] = 4'($urandom_range(10, 15));
            model(rop, ra, rb, er, en, eo, ee, el);
            run_op($sformatf("rand%0d", n), rop, ra, rb, er, en, eo, ee, el);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_alu.md
BCD_ALU -- requirements
Module: bcd_alu

Interface
REQ-001 SHALL provide parameter DIGITS, default 6, the number of packed BCD digits per operand and result (legal range 2..8).
REQ-002 SHALL have port CLOCK_50  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  operation request, sampled each cycle.
REQ-005 SHALL have port op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-006 SHALL have port a  input  4*DIGITS  packed BCD operand A; digit 0 in bits [3:0].
REQ-007 SHALL have port b  input  4*DIGITS  packed BCD operand B.
REQ-008 SHALL have port busy  output  1  high while an accepted operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking valid result and flags.
REQ-010 SHALL have port result  output  4*DIGITS  packed BCD result, held until the next done.
REQ-011 SHALL have port neg  output  1  subtraction result is negative; result holds the magnitude.
REQ-012 SHALL have port ovf  output  1  true result does not fit in DIGITS digits.
REQ-013 SHALL have port err  output  1  invalid digit (>9) in a or b, or reserved opcode.

Function
REQ-014 SHALL accept an operation on a cycle where start=1 and busy=0; a, b and op are latched at acceptance (call this cycle 0) and are ignored afterwards.
REQ-015 SHALL ignore start while busy=1 or done=1; no queueing.
REQ-016 SHALL use states IDLE, MSHIFT, MADD and DONE: add/sub/err go IDLE->DONE; mul goes IDLE->MSHIFT->(MADD)*->...->DONE; DONE->IDLE unconditionally.
REQ-017 SHALL detect an error when any operand digit is >9 or op=11; the block then asserts done at cycle 1 with err=1, result=0, and neg=ovf=0.
REQ-018 SHALL compute add in one cycle, with done at cycle 1 and busy low throughout; result is the low DIGITS digits of a+b, and ovf is the decimal carry out of the top digit.
REQ-019 SHALL compute sub as a + 9's complement(b) + 1: carry out=1 gives result=a-b, neg=0; carry out=0 gives result = 10's complement of the sum (=b-a), neg=1; ovf=0; done at cycle 1.
REQ-020 SHALL compute mul by digit-serial shift-and-add into a 2*DIGITS-digit BCD accumulator cleared at acceptance, processing multiplier digits MSD first.
REQ-021 SHALL, in MSHIFT, shift the accumulator left one digit and load a digit counter with the current b digit; the next state is MADD if that digit is nonzero, otherwise the next digit or DONE.
REQ-022 SHALL, in MADD, add the latched a to the accumulator once per cycle and decrement the counter; after the add that brings the counter to 0, go to the next digit's MSHIFT, or to DONE after digit 0.
REQ-023 SHALL raise done at cycle DIGITS+S+1 for mul, where S is the sum of the b digits; busy is high from cycle 1 until the cycle before done.
REQ-024 SHALL set result for mul to the low DIGITS accumulator digits, with ovf=1 iff any upper accumulator digit is nonzero; neg=0.
REQ-025 SHALL keep result, neg, ovf and err stable from done until the next done, or until reset.
REQ-026 SHALL allow a new start to be accepted in the cycle after done; back-to-back operations lose no cycles beyond the stated latency.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, go to IDLE and clear busy, done, result, neg, ovf, err, the accumulator and the counter to 0.
REQ-028 SHALL abort an in-progress operation when reset mid-operation, with no done pulse; busy=0 on the cycle after reset.
REQ-029 SHALL give rst priority over start in the same cycle; the start is not accepted.

Configuration
REQ-030 SHALL, with macro BCD_ALU_SAT_EN defined, force result to all 9s (e.g. 999999 at DIGITS=6) whenever ovf=1 for add or mul.
REQ-031 SHALL, without BCD_ALU_SAT_EN, truncate result to the low DIGITS digits on overflow; ovf behaviour is identical in both builds.

Verification
REQ-032 SHALL cover add: a=999999, b=000001 -> done at cycle 1, result=000000, ovf=1 (999999 with BCD_ALU_SAT_EN).
REQ-033 SHALL cover sub: a=000123, b=000456 -> done at cycle 1, result=000333, neg=1, ovf=0; then a=000456, b=000123 -> result=000333, neg=0.
REQ-034 SHALL cover mul: a=000012, b=000034 -> busy cycles 1..13, done at cycle 14, result=000408, ovf=0.
REQ-035 SHALL cover mul overflow: a=001000, b=001000 -> done at cycle 8, ovf=1, result=000000 (999999 with BCD_ALU_SAT_EN).
REQ-036 SHALL cover errors: a=00000A with op=00, or op=11 -> done at cycle 1, err=1, result=0.
REQ-037 SHALL cover abort: rst at cycle 5 of a mul, with start pulsed at cycles 3..4 -> extra start ignored, no done, all outputs 0 on the cycle after reset.
